// File: rtl/cla_adder4_pkg.sv
// Shared constants and the lookahead carry helper for the cla_adder4 family.
//   DEF_WIDTH  : default operand width
//   DEF_GROUP  : default bits per lookahead group
//   LA_MAX     : widest carry vector the helper can form; it bounds both GROUP
//                and the number of groups seen by the second-level lookahead
//   la_carries : closed-form carry vector c[0..LA_MAX] from (p, g, cin)
package cla_adder4_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_GROUP = 4;
  localparam int LA_MAX    = 16;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, each carry built as an
  // independent sum of products so that no carry depends on a lower one.
  // Callers zero-extend narrower p/g vectors and keep only the bits they need.
  function automatic logic [LA_MAX:0] la_carries(input logic [LA_MAX-1:0] p,
                                                 input logic [LA_MAX-1:0] g,
                                                 input logic              cin);
    logic [LA_MAX:0] c;
    logic            term;
    logic            prod;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < LA_MAX; i++) begin
      term = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      term     = term | (prod & cin);
      c[i + 1] = term;
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead unit, purely combinational.
//   a, b    : operand slices
//   cin     : carry into the group
//   s       : sum slice
//   group_p : every bit of the group propagates
//   group_g : the group generates a carry on its own
//   cout    : carry out of the group
module cla_group
  import cla_adder4_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             group_p,
  output logic             group_g,
  output logic             cout
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a ^ b;
  assign g = a & b;
  assign c = (GROUP + 1)'(la_carries(LA_MAX'(p), LA_MAX'(g), cin));

  assign s       = p ^ c[GROUP-1:0];
  assign cout    = c[GROUP];
  assign group_p = &p;
  // Group generate is the top carry of the same lookahead with cin forced low.
  assign group_g = 1'(la_carries(LA_MAX'(p), LA_MAX'(g), 1'b0) >> GROUP);

endmodule

// File: rtl/cla_adder4.sv
// Registered two-level carry-lookahead adder: {Cout, sum} = A + B + Cin.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : A/B/Cin are valid this cycle
//   A, B, Cin  : unsigned addends and carry-in
//   sum, Cout  : registered result, one cycle after an accepted input
//   out_valid  : sum/Cout belong to an accepted input
//   grp_p/g    : registered block propagate/generate for cascading
module cla_adder4
  import cla_adder4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             out_valid,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int NGRP = WIDTH / GROUP;

  logic [NGRP-1:0]  gp;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  cout_unused;
  logic [NGRP:0]    gc;
  logic [WIDTH-1:0] sum_p0;
  logic             cout_p0;
  logic             blk_p_p0;
  logic             blk_g_p0;

  // Stage p0: group lookahead units and second-level lookahead.
  // Group carry-ins come from the group P/G terms, never from a neighbour's
  // cout, so the per-group cout outputs are not needed here.
  assign gc = (NGRP + 1)'(la_carries(LA_MAX'(gp), LA_MAX'(gg), Cin));

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a       (A[k*GROUP +: GROUP]),
      .b       (B[k*GROUP +: GROUP]),
      .cin     (gc[k]),
      .s       (sum_p0[k*GROUP +: GROUP]),
      .group_p (gp[k]),
      .group_g (gg[k]),
      .cout    (cout_unused[k])
    );
  end

  assign cout_p0  = gc[NGRP];
  assign blk_p_p0 = &gp;
  assign blk_g_p0 = 1'(la_carries(LA_MAX'(gp), LA_MAX'(gg), 1'b0) >> NGRP);

  // Stage p0 -> output register; results hold while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      Cout      <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_p0;
        Cout  <= cout_p0;
        grp_p <= blk_p_p0;
        grp_g <= blk_g_p0;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder4.sv
module tb_cla_adder4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        c4 = 1'b0;
  logic [3:0]  s4;
  logic        co4, ov4, gp4, gg4;

  logic        v16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        c16 = 1'b0;
  logic [15:0] s16;
  logic        co16, ov16, gp16, gg16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_adder4 #(.WIDTH(4), .GROUP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .Cin(c4),
    .sum(s4), .Cout(co4), .out_valid(ov4), .grp_p(gp4), .grp_g(gg4)
  );

  cla_adder4 #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .A(a16), .B(b16), .Cin(c16),
    .sum(s16), .Cout(co16), .out_valid(ov16), .grp_p(gp16), .grp_g(gg16)
  );

  // Reference model: plain integer addition. Packed as
  // {out_valid, Cout, grp_p, grp_g, sum}.
  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c);
    int unsigned tot, tot0;
    logic        p, g;
    tot  = a + b + c;
    tot0 = a + b;
    p    = ((a ^ b) == 4'hF);
    g    = (tot0 >= 16);
    return {1'b1, (tot >= 16), p, g, 4'(tot)};
  endfunction

  function automatic logic [19:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    int unsigned tot, tot0;
    logic        p, g;
    tot  = a + b + c;
    tot0 = a + b;
    p    = ((a ^ b) == 16'hFFFF);
    g    = (tot0 >= 65536);
    return {1'b1, (tot >= 65536), p, g, 16'(tot)};
  endfunction

  // Present one valid 4-bit vector at the falling edge, then wait until just
  // after the rising edge that captures it. in_valid stays high afterwards.
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    a4 = a; b4 = b; c4 = c; v4 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({ov4, co4, gp4, gg4, s4} !== 8'h00) begin
      failures++;
      $display("FAIL reset_initial: got %b required %b", {ov4, co4, gp4, gg4, s4}, 8'h00);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [3:0] ta [6] = '{4'b0010, 4'b1010, 4'b1110, 4'b1010, 4'b1011, 4'b1111};
    logic [3:0] tb [6] = '{4'b0111, 4'b0011, 4'b0011, 4'b1111, 4'b1011, 4'b1111};
    logic       tc [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] te [6] = '{5'b01010, 5'b01101, 5'b10010, 5'b11010, 5'b10110, 5'b11110};
    for (int i = 0; i < 6; i++) begin
      drive4(ta[i], tb[i], tc[i]);
      checks++;
      if ({ov4, co4, s4} !== {1'b1, te[i]}) begin
        failures++;
        $display("FAIL directed_%0d: got v=%b cout=%b sum=%b required v=1 cout=%b sum=%b",
                 i, ov4, co4, s4, te[i][4], te[i][3:0]);
      end
    end
  endtask

  task automatic test_propagate;
    drive4(4'b1111, 4'b0000, 1'b1);
    checks++;
    if ({ov4, co4, gp4, gg4, s4} !== {1'b1, 1'b1, 1'b1, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL propagate_chain: got v=%b cout=%b p=%b g=%b sum=%b required v=1 cout=1 p=1 g=0 sum=0000",
               ov4, co4, gp4, gg4, s4);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] exp;
    logic [3:0] a, b;
    logic       c;
    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
      q.push_back(model4(a, b, c));
      drive4(a, b, c);
      exp = q.pop_front();
      checks++;
      if ({ov4, co4, gp4, gg4, s4} !== exp) begin
        failures++;
        $display("FAIL back_to_back_%0d: got %b required %b", i, {ov4, co4, gp4, gg4, s4}, exp);
      end
    end
  endtask

  task automatic test_hold;
    logic [7:0] exp;
    drive4(4'b0110, 4'b1101, 1'b1);
    exp = model4(4'b0110, 4'b1101, 1'b1);
    @(negedge clk);
    v4 = 1'b0;
    a4 = 4'b0001; b4 = 4'b0001; c4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({ov4, co4, gp4, gg4, s4} !== {1'b0, exp[6:0]}) begin
        failures++;
        $display("FAIL hold_gap_%0d: got %b required %b", i, {ov4, co4, gp4, gg4, s4}, {1'b0, exp[6:0]});
      end
    end
  endtask

  task automatic test_reset_midstream;
    drive4(4'b1111, 4'b1111, 1'b1);
    checks++;
    if ({ov4, co4, gp4, gg4, s4} !== model4(4'b1111, 4'b1111, 1'b1)) begin
      failures++;
      $display("FAIL all_ones_wrap: got %b required %b", {ov4, co4, gp4, gg4, s4},
               model4(4'b1111, 4'b1111, 1'b1));
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ov4, co4, gp4, gg4, s4} !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: got %b required %b", {ov4, co4, gp4, gg4, s4}, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    drive4(4'b0101, 4'b0011, 1'b0);
    checks++;
    if ({ov4, co4, gp4, gg4, s4} !== model4(4'b0101, 4'b0011, 1'b0)) begin
      failures++;
      $display("FAIL first_after_reset: got %b required %b", {ov4, co4, gp4, gg4, s4},
               model4(4'b0101, 4'b0011, 1'b0));
    end
  endtask

  task automatic test_exhaustive4;
    logic [7:0] exp;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          drive4(4'(a), 4'(b), 1'(c));
          exp = model4(4'(a), 4'(b), 1'(c));
          checks++;
          if ({ov4, co4, gp4, gg4, s4} !== exp) begin
            failures++;
            $display("FAIL exhaustive a=%0d b=%0d c=%0d: got %b required %b",
                     a, b, c, {ov4, co4, gp4, gg4, s4}, exp);
          end
        end
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic test_random16;
    logic [19:0] exp;
    logic [15:0] a, b;
    logic        c;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0: begin a = 16'hFFFF; b = 16'hFFFF; c = 1'b1; end
        1: begin a = 16'hFFFF; b = 16'h0000; c = 1'b1; end
        2: begin a = 16'hA5A5; b = 16'h5A5A; c = 1'b0; end
        3: begin a = 16'h0F0F; b = 16'h00F1; c = 1'b0; end
        default: begin a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); end
      endcase
      @(negedge clk);
      a16 = a; b16 = b; c16 = c; v16 = 1'b1;
      @(posedge clk);
      #1;
      exp = model16(a, b, c);
      checks++;
      if ({ov16, co16, gp16, gg16, s16} !== exp) begin
        failures++;
        $display("FAIL random16_%0d a=%h b=%h c=%b: got %h required %h",
                 i, a, b, c, {ov16, co16, gp16, gg16, s16}, exp);
      end
    end
    @(negedge clk);
    v16 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ov16 !== 1'b0) begin
      failures++;
      $display("FAIL random16_idle: got out_valid=%b required 0", ov16);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_propagate;
    test_back_to_back;
    test_hold;
    test_reset_midstream;
    test_exhaustive4;
    test_random16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
